// File: rtl/gpio_debounce_pkg.sv
// Shared constants for the GPIO input conditioning path: default width, debounce
// counter width, and the default stability/prescale values also used by the CPU register map.
package gpio_debounce_pkg;

    localparam int GPIO_WIDTH     = 32;
    localparam int DB_CNT_W       = 4;
    localparam int DEF_STABLE_CNT = 4;
    localparam int DEF_PRESCALE   = 0;

    // Accept once the window counter has seen STABLE_CNT-1 earlier differing ticks.
    function automatic logic window_done(input logic [DB_CNT_W-1:0] cnt, input int stable_cnt);
        return cnt == DB_CNT_W'(stable_cnt - 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: synchroniser chain, stability-window debouncer and registered edge pulses.
module gpio_debounce_bit
    import gpio_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   STABLE_CNT  = DEF_STABLE_CNT,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic tick,
    output logic clean,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic [DB_CNT_W-1:0]    cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
        end
    end

    // A sample matching the clean level restarts the window, so any glitch is forgotten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean <= RESET_BIT;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == clean) begin
                cnt <= '0;
            end else if (tick) begin
                if (window_done(cnt, STABLE_CNT)) begin
                    clean <= s;
                    cnt   <= '0;
                    rise  <= s;
                    fall  <= ~s;
                end else begin
                    cnt <= cnt + DB_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input conditioning: per-bit sync + debounce, shared sample-tick prescaler, and
// optional sticky edge capture with level interrupt (enabled by GPIO_DEBOUNCE_IRQ_EN).
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int               WIDTH       = GPIO_WIDTH,
    parameter int               SYNC_STAGES = 2,
    parameter int               PRESCALE_W  = 16,
    parameter int               STABLE_CNT  = DEF_STABLE_CNT,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      pin_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      clean_out,
    output logic [WIDTH-1:0]      rise,
    output logic [WIDTH-1:0]      fall
`ifdef GPIO_DEBOUNCE_IRQ_EN
    ,
    input  logic [WIDTH-1:0]      irq_rise_en,
    input  logic [WIDTH-1:0]      irq_fall_en,
    input  logic [WIDTH-1:0]      irq_clr,
    output logic [WIDTH-1:0]      irq_status,
    output logic                  irq
`endif
);

    logic [PRESCALE_W-1:0] pc;
    logic                  tick;

    // Comparing with >= lets a lowered prescale take effect on the very next cycle.
    assign tick = (pc >= prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PRESCALE_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        gpio_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT),
            .RESET_BIT   (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .pin   (pin_in[i]),
            .tick  (tick),
            .clean (clean_out[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] capture;

    assign capture = (rise & irq_rise_en) | (fall & irq_fall_en);

    // New captures take priority over a write-1-to-clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | capture;
            irq        <= |irq_status;
        end
    end
`endif

endmodule
